// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic {IDLE, FILL} state_e;

  localparam logic [31:0] NOP = 32'h00000013;

  // Word-addressed: 30 address bits remain above the byte offset, minus the index.
  function automatic int unsigned tag_width(input int unsigned lines);
    return 30 - $clog2(lines);
  endfunction

endpackage

// File: rtl/icache_array.sv
// Tag and data storage: one asynchronous read port, one synchronous write port.
module icache_array
  import icache_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned TAG_W = 26
) (
  input  logic             clock,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data
);

  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_tag  = tag_mem[rd_idx];
  assign rd_data = data_mem[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with flush and req/ack line fill.
module icache
  import icache_pkg::*;
#(
  parameter int unsigned LINES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_data,
  output logic        stall,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = tag_width(LINES);

  state_e           state_q;
  logic [LINES-1:0] valid_q;
  logic             dropped_q;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_data;
  logic             hit;
  logic             unused_addr_bits;

  assign idx      = inst_addr[IDX_W+1:2];
  assign tag      = inst_addr[31:IDX_W+2];
  // mem_addr doubles as the latched fill address for the whole FILL phase.
  assign fill_idx = mem_addr[IDX_W+1:2];
  assign fill_tag = mem_addr[31:IDX_W+2];

  assign unused_addr_bits = ^inst_addr[1:0];

  icache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clock   (clock),
    .rd_idx  (idx),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   ((state_q == FILL) && mem_ack),
    .wr_idx  (fill_idx),
    .wr_tag  (fill_tag),
    .wr_data (mem_rdata)
  );

  assign hit       = (state_q == IDLE) && valid_q[idx] && (rd_tag == tag);
  assign stall     = !hit;
  assign inst_data = hit ? rd_data : NOP;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      valid_q   <= '0;
      dropped_q <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
    end else begin
      if (flush) valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (!hit && !flush) begin
            state_q   <= FILL;
            mem_req   <= 1'b1;
            mem_addr  <= {inst_addr[31:2], 2'b00};
            dropped_q <= 1'b0;
          end
        end
        FILL: begin
          if (flush) dropped_q <= 1'b1;
          if (mem_ack) begin
            state_q <= IDLE;
            mem_req <= 1'b0;
            // A flush seen at any point of the fill, including the ack cycle, keeps the line invalid.
            if (!dropped_q && !flush) valid_q[fill_idx] <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: fills, conflicts, flush, reset during fill, address change mid-fill.
module tb_icache;

  localparam logic [31:0] NOP_V = 32'h00000013;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        stall;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_chk = 0;
  int n_bad = 0;

  icache #(
    .LINES (16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .inst_addr (inst_addr),
    .inst_data (inst_data),
    .stall     (stall),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Miss on a, memory answers d after lat cycles of mem_req; ends in the hit cycle.
  task automatic do_miss(input logic [31:0] a, input logic [31:0] d, input int lat);
    int stalls;
    stalls = 0;
    inst_addr = a;
    #1;
    check("miss_stall", {31'b0, stall}, 32'd1);
    check("miss_nop", inst_data, NOP_V);
    if (stall) stalls++;
    for (int c = 1; c <= lat; c++) begin
      tick();
      if (c == lat) begin
        mem_ack   = 1'b1;
        mem_rdata = d;
      end
      #1;
      check("fill_req", {31'b0, mem_req}, 32'd1);
      check("fill_addr", mem_addr, {a[31:2], 2'b00});
      if (stall) stalls++;
    end
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    #1;
    check("fill_hit", {31'b0, stall}, 32'd0);
    check("fill_data", inst_data, d);
    check("req_drop", {31'b0, mem_req}, 32'd0);
    check("stall_cycles", stalls, lat + 1);
  endtask

  task automatic expect_hit(input logic [31:0] a, input logic [31:0] d);
    inst_addr = a;
    #1;
    check("hit_stall", {31'b0, stall}, 32'd0);
    check("hit_data", inst_data, d);
  endtask

  initial begin
    reset     = 1'b1;
    inst_addr = '0;
    flush     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    tick();
    tick();
    check("rst_req", {31'b0, mem_req}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd1);
    check("rst_nop", inst_data, NOP_V);
    reset = 1'b0;

    // Basic fill with L = 3, then zero-stall repeat fetch.
    do_miss(32'h100, 32'hDEADBEEF, 3);
    tick();
    expect_hit(32'h100, 32'hDEADBEEF);
    expect_hit(32'h102, 32'hDEADBEEF);

    // Conflict on index 0.
    do_miss(32'h140, 32'hCAFE0140, 2);
    inst_addr = 32'h100;
    #1;
    check("conflict_miss", {31'b0, stall}, 32'd1);
    do_miss(32'h100, 32'hDEADBEEF, 1);

    // Flush invalidates all lines.
    do_miss(32'h104, 32'h11110104, 1);
    do_miss(32'h108, 32'h22220108, 2);
    expect_hit(32'h100, 32'hDEADBEEF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    do_miss(32'h100, 32'hDEADBEEF, 1);
    do_miss(32'h104, 32'h11110104, 1);
    do_miss(32'h108, 32'h22220108, 1);

    // Flush mid-fill drops the line.
    inst_addr = 32'h200;
    tick();
    check("drop_req", {31'b0, mem_req}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'hAAAA0200;
    tick();
    mem_ack = 1'b0;
    #1;
    check("drop_stall", {31'b0, stall}, 32'd1);
    check("drop_req_low", {31'b0, mem_req}, 32'd0);
    do_miss(32'h200, 32'hBBBB0200, 2);

    // Flush coincident with ack also drops.
    inst_addr = 32'h280;
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'hCCCC0280;
    flush     = 1'b1;
    tick();
    mem_ack = 1'b0;
    flush   = 1'b0;
    #1;
    check("ackflush_stall", {31'b0, stall}, 32'd1);
    do_miss(32'h280, 32'hDDDD0280, 1);

    // Reset during fill; a late ack is ignored.
    inst_addr = 32'h380;
    tick();
    check("rstfill_req", {31'b0, mem_req}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rstfill_req_low", {31'b0, mem_req}, 32'd0);
    check("rstfill_stall", {31'b0, stall}, 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h12345678;
    tick();
    mem_ack = 1'b0;
    #1;
    check("late_ack_stall", {31'b0, stall}, 32'd1);
    check("refetch_req", {31'b0, mem_req}, 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BADF00D;
    tick();
    mem_ack = 1'b0;
    #1;
    check("refill_data", inst_data, 32'h0BADF00D);

    // Address change during fill completes the original line first.
    inst_addr = 32'h300;
    tick();
    inst_addr = 32'h304;
    #1;
    check("chg_stall0", {31'b0, stall}, 32'd1);
    check("chg_addr", mem_addr, 32'h300);
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'h300DA7A0;
    #1;
    check("chg_stall1", {31'b0, stall}, 32'd1);
    tick();
    mem_ack = 1'b0;
    #1;
    check("chg_stall2", {31'b0, stall}, 32'd1);
    check("chg_req_low", {31'b0, mem_req}, 32'd0);
    do_miss(32'h304, 32'h304DA7A0, 2);
    expect_hit(32'h300, 32'h300DA7A0);

    // Stray ack in IDLE changes nothing.
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFFFFFF;
    tick();
    mem_ack = 1'b0;
    #1;
    check("idle_ack_data", inst_data, 32'h300DA7A0);
    check("idle_ack_req", {31'b0, mem_req}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
